dsp_post_adder_acc: RTL and testbench



---
 rtl/dsp_pkg.sv | 21 ++
 rtl/dsp_en_reg.sv | 32 +++
 rtl/dsp_opnd_mux.sv | 23 ++
 rtl/dsp_post_adder_acc.sv | 127 ++++++++++++
 tb/tb_dsp_post_adder_acc.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP slice: operand-select encodings, OPMODE bit positions
// and the default datapath width.
package dsp_pkg;

    localparam int unsigned DSP_WIDTH = 48;

    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    localparam int unsigned OP_X_LSB = 0;
    localparam int unsigned OP_Z_LSB = 2;
    localparam int unsigned OP_SUB   = 7;

endpackage

// File: rtl/dsp_en_reg.sv
// Clock-enabled register with asynchronous active-low reset to zero.
// Reset wins over the enable.
module dsp_en_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dsp_opnd_mux.sv
// 4:1 operand selector used for both the X and Z post-adder inputs.
module dsp_opnd_mux #(
    parameter int unsigned WIDTH = 48
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        unique case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP slice post-adder/accumulator: Z +/- (X + CIN) with optional P and CARRYOUT
// registers, P feedback for multiply-accumulate, and cascade outputs.
module dsp_post_adder_acc
    import dsp_pkg::*;
#(
    parameter int unsigned PREG        = 1,
    parameter int unsigned CARRYOUTREG = 1,
    parameter int unsigned WIDTH       = DSP_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cep,
    input  logic              cecarryin,
    input  logic [WIDTH-13:0] m,
    input  logic [WIDTH-1:0]  dab,
    input  logic [WIDTH-1:0]  c,
    input  logic [WIDTH-1:0]  pcin,
    input  logic              cin,
    input  logic [7:0]        opmode,
    output logic [WIDTH-1:0]  p,
    output logic [WIDTH-1:0]  pcout,
    output logic              carryout,
    output logic              carryoutf,
    output logic              illegal_op
);

    logic [1:0]       x_sel, z_sel;
    logic [WIDTH-1:0] p_fb, x_opnd, z_opnd, p_next;
    logic [WIDTH:0]   x_ext, z_ext, cin_ext, r;
    logic             co_next, p_selected;
    logic             unused_inputs;

    assign x_sel      = opmode[OP_X_LSB +: 2];
    assign z_sel      = opmode[OP_Z_LSB +: 2];
    assign p_selected = (x_sel == X_P) || (z_sel == Z_P);

    dsp_opnd_mux #(.WIDTH(WIDTH)) u_x_mux (
        .sel (x_sel),
        .in0 ('0),
        .in1 ({12'b0, m}),
        .in2 (p_fb),
        .in3 (dab),
        .out (x_opnd)
    );

    dsp_opnd_mux #(.WIDTH(WIDTH)) u_z_mux (
        .sel (z_sel),
        .in0 ('0),
        .in1 (pcin),
        .in2 (p_fb),
        .in3 (c),
        .out (z_opnd)
    );

    // One extra bit carries the add carry-out, or the borrow when subtracting.
    always_comb begin
        x_ext   = {1'b0, x_opnd};
        z_ext   = {1'b0, z_opnd};
        cin_ext = {{WIDTH{1'b0}}, cin};
        if (opmode[OP_SUB]) begin
            r = z_ext - (x_ext + cin_ext);
        end else begin
            r = z_ext + x_ext + cin_ext;
        end
    end

    assign p_next  = r[WIDTH-1:0];
    assign co_next = r[WIDTH];

    if (PREG != 0) begin : g_preg
        logic [WIDTH-1:0] p_q;

        dsp_en_reg #(.W(WIDTH)) u_p_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cep),
            .d     (p_next),
            .q     (p_q)
        );

        assign p_fb       = p_q;
        assign p          = p_q;
        assign illegal_op = 1'b0;
    end else begin : g_pcomb
        logic illegal_d, illegal_q;

        // Without a P register there is nothing legal to feed back.
        assign p_fb = '0;
        assign p    = p_next;

        always_comb begin
            illegal_d = illegal_q | p_selected;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                illegal_q <= 1'b0;
            end else begin
                illegal_q <= illegal_d;
            end
        end

        assign illegal_op = illegal_q;
    end

    if (CARRYOUTREG != 0) begin : g_coreg
        logic co_q;

        dsp_en_reg #(.W(1)) u_co_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cecarryin),
            .d     (co_next),
            .q     (co_q)
        );

        assign carryout = co_q;
    end else begin : g_cocomb
        assign carryout = co_next;
    end

    assign pcout     = p;
    assign carryoutf = carryout;

    assign unused_inputs = ^{opmode[6:4], cep, cecarryin, p_selected};

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Self-checking bench: registered (PREG=1, CARRYOUTREG=1) and combinational
// (PREG=0, CARRYOUTREG=0) instances driven in parallel against an arithmetic model.
module tb_dsp_post_adder_acc;

    localparam logic [63:0] LIM = 64'h1_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, cep, cecarryin, cin;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic [7:0]  opmode;

    logic [47:0] p, pcout, p0, pcout0;
    logic        carryout, carryoutf, illegal_op, co0, cof0, ill0;

    int checks = 0;
    int errors = 0;

    logic [47:0] mp;
    logic        mco;
    logic        mill0;

    always #5 clk = ~clk;

    dsp_post_adder_acc #(.PREG(1), .CARRYOUTREG(1), .WIDTH(48)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cep        (cep),
        .cecarryin  (cecarryin),
        .m          (m),
        .dab        (dab),
        .c          (c),
        .pcin       (pcin),
        .cin        (cin),
        .opmode     (opmode),
        .p          (p),
        .pcout      (pcout),
        .carryout   (carryout),
        .carryoutf  (carryoutf),
        .illegal_op (illegal_op)
    );

    dsp_post_adder_acc #(.PREG(0), .CARRYOUTREG(0), .WIDTH(48)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cep        (cep),
        .cecarryin  (cecarryin),
        .m          (m),
        .dab        (dab),
        .c          (c),
        .pcin       (pcin),
        .cin        (cin),
        .opmode     (opmode),
        .p          (p0),
        .pcout      (pcout0),
        .carryout   (co0),
        .carryoutf  (cof0),
        .illegal_op (ill0)
    );

    // Returns {carry/borrow, result} from plain integer arithmetic.
    function automatic logic [48:0] ref_calc(input logic [7:0] op, input logic [47:0] pfb);
        logic [63:0] xv, zv, tot, need;
        logic        co;
        logic [63:0] pv;
        case (op[1:0])
            2'd0:    xv = 64'd0;
            2'd1:    xv = {28'd0, m};
            2'd2:    xv = {16'd0, pfb};
            default: xv = {16'd0, dab};
        endcase
        case (op[3:2])
            2'd0:    zv = 64'd0;
            2'd1:    zv = {16'd0, pcin};
            2'd2:    zv = {16'd0, pfb};
            default: zv = {16'd0, c};
        endcase
        if (!op[7]) begin
            tot = zv + xv + {63'd0, cin};
            co  = (tot >= LIM);
            pv  = co ? tot - LIM : tot;
        end else begin
            need = xv + {63'd0, cin};
            co   = (need > zv);
            pv   = co ? zv + LIM - need : zv - need;
        end
        return {co, pv[47:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [48:0] r0;
        r0 = ref_calc(opmode, 48'd0);
        chk({tag, ".p"}, {16'd0, p}, {16'd0, mp});
        chk({tag, ".pcout"}, {16'd0, pcout}, {16'd0, mp});
        chk({tag, ".co"}, {63'd0, carryout}, {63'd0, mco});
        chk({tag, ".cof"}, {63'd0, carryoutf}, {63'd0, mco});
        chk({tag, ".p0"}, {16'd0, p0}, {16'd0, r0[47:0]});
        chk({tag, ".pcout0"}, {16'd0, pcout0}, {16'd0, r0[47:0]});
        chk({tag, ".co0"}, {63'd0, co0}, {63'd0, r0[48]});
        chk({tag, ".cof0"}, {63'd0, cof0}, {63'd0, r0[48]});
        chk({tag, ".ill0"}, {63'd0, ill0}, {63'd0, mill0});
        chk({tag, ".ill"}, {63'd0, illegal_op}, 64'd0);
    endtask

    // Advance one clock edge; inputs were set away from the edge.
    task automatic edge_step();
        logic [48:0] r;
        r = ref_calc(opmode, mp);
        if (rst_n && (opmode[1:0] == 2'd2 || opmode[3:2] == 2'd2)) mill0 = 1'b1;
        @(posedge clk);
        #1;
        if (cep) mp = r[47:0];
        if (cecarryin) mco = r[48];
    endtask

    // Asynchronous reset pulse, called just after an edge so no edge falls inside it.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        mp    = '0;
        mco   = 1'b0;
        mill0 = 1'b0;
        check_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cep = 1'b1; cecarryin = 1'b1; cin = 1'b0;
        m = '0; dab = '0; c = '0; pcin = '0; opmode = 8'h00;
        mp = '0; mco = 1'b0; mill0 = 1'b0;
        #2;
        check_all("rst_init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-run discards P without a clock edge.
        opmode = 8'h03; dab = 48'h123;
        edge_step();
        chk("pre_rst.p", {16'd0, p}, 64'h123);
        async_reset("mid_rst");
        opmode = 8'h01; m = 36'd5;
        edge_step();
        check_all("post_rst");
        chk("post_rst.p5", {16'd0, p}, 64'd5);

        // Accumulate m=3 from zero.
        opmode = 8'h00; edge_step();
        opmode = 8'h09; m = 36'd3; cin = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            edge_step();
            check_all("acc");
            chk("acc.val", {16'd0, p}, 64'(3 * i));
        end

        // Same with cep low on the third edge.
        opmode = 8'h00; edge_step();
        opmode = 8'h09;
        for (int i = 1; i <= 4; i++) begin
            cep = (i != 3);
            edge_step();
            check_all("acc_cep");
        end
        chk("acc_cep.final", {16'd0, p}, 64'd9);
        cep = 1'b1;

        // Wrap and one-cycle carry.
        opmode = 8'h0F; c = '1; dab = 48'd1; cin = 1'b0;
        edge_step();
        check_all("wrap");
        chk("wrap.p", {16'd0, p}, 64'd0);
        chk("wrap.co", {63'd0, carryout}, 64'd1);
        dab = 48'd0;
        edge_step();
        check_all("wrap_clr");
        chk("wrap_clr.co", {63'd0, carryout}, 64'd0);

        // Subtract and borrow.
        opmode = 8'h8F; c = 48'd10; dab = 48'd3; cin = 1'b1;
        edge_step();
        check_all("sub");
        chk("sub.p", {16'd0, p}, 64'd6);
        c = 48'd2; cin = 1'b0;
        edge_step();
        check_all("borrow");
        chk("borrow.p", {16'd0, p}, 64'hFFFF_FFFF_FFFF);
        chk("borrow.co", {63'd0, carryout}, 64'd1);

        // Cascade in, then independent enables.
        opmode = 8'h04; pcin = 48'd100; cin = 1'b1;
        edge_step();
        check_all("pcin");
        chk("pcin.pcout", {16'd0, pcout}, 64'd101);
        opmode = 8'h0F; c = '1; dab = 48'd5; cin = 1'b0; cecarryin = 1'b0;
        edge_step();
        check_all("ce_co_off");
        chk("ce_co_off.co", {63'd0, carryout}, 64'd0);
        chk("ce_co_off.p", {16'd0, p}, 64'd4);
        cep = 1'b0; cecarryin = 1'b1;
        edge_step();
        check_all("ce_p_off");
        chk("ce_p_off.co", {63'd0, carryout}, 64'd1);
        chk("ce_p_off.p", {16'd0, p}, 64'd4);
        cep = 1'b1;

        // Randomized mix of opmodes, operands and enables.
        for (int i = 0; i < 60; i++) begin
            opmode    = 8'($urandom);
            m         = 36'({$urandom, $urandom});
            dab       = ($urandom_range(3) == 0) ? '1 : 48'({$urandom, $urandom});
            c         = ($urandom_range(3) == 0) ? '1 : 48'({$urandom, $urandom});
            pcin      = 48'({$urandom, $urandom});
            cin       = 1'($urandom);
            cep       = ($urandom_range(4) != 0);
            cecarryin = ($urandom_range(4) != 0);
            #1;
            check_all("rnd_pre");
            edge_step();
            check_all("rnd");
        end
        cep = 1'b1; cecarryin = 1'b1;

        // Combinational build: P select reads as zero and flags sticky illegal_op.
        async_reset("ill_rst");
        opmode = 8'h0E; c = 48'h55; dab = 48'h1234;
        #1;
        chk("ill.p0_comb", {16'd0, p0}, 64'h55);
        chk("ill.before", {63'd0, ill0}, 64'd0);
        edge_step();
        check_all("ill_set");
        chk("ill.set", {63'd0, ill0}, 64'd1);
        opmode = 8'h0F;
        edge_step();
        check_all("ill_sticky");
        chk("ill.sticky", {63'd0, ill0}, 64'd1);
        async_reset("ill_clr");
        chk("ill.clr", {63'd0, ill0}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
